lfsr_descrambler_rx: RTL and testbench



---
 rtl/lfsr_pkg.sv | 37 +++
 rtl/lfsr_step_n.sv | 18 +
 rtl/lfsr_descrambler_rx.sv | 142 ++++++++++++++
 tb/tb_lfsr_descrambler_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 34-bit keystream LFSR used by both the scrambler and the descrambler.
// Holds the fixed width, the tap positions, the seed register map and the receive FSM encoding.
package lfsr_pkg;

  localparam int POLY_WIDTH = 34;

  // Bit 0 is the plain feedback input; these bits also XOR in the feedback from the MSB.
  localparam int TAP_A = 8;
  localparam int TAP_B = 12;
  localparam int TAP_C = 17;

  localparam logic [11:0] ADDR_SEED_LO = 12'h0b1;
  localparam logic [11:0] ADDR_SEED_HI = 12'h0b2;

  localparam int          DEF_NUM_OF_STEPS = 18;
  localparam int          DEF_DATA_WIDTH   = 18;
  localparam logic [17:0] DEF_SYNC_WORD    = 18'h2A5C3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2,
    FAIL   = 2'd3
  } rx_state_e;

  function automatic logic [POLY_WIDTH-1:0] lfsr_step(input logic [POLY_WIDTH-1:0] s);
    logic [POLY_WIDTH-1:0] n;
    logic                  fb;
    fb       = s[POLY_WIDTH-1];
    n        = {s[POLY_WIDTH-2:0], fb};
    n[TAP_A] = s[TAP_A-1] ^ fb;
    n[TAP_B] = s[TAP_B-1] ^ fb;
    n[TAP_C] = s[TAP_C-1] ^ fb;
    return n;
  endfunction

endpackage

// File: rtl/lfsr_step_n.sv
// Combinational multi-step LFSR advance: state_o is state_i stepped NUM_OF_STEPS times.
// Shared with the transmit-side scrambler so both ends walk the identical sequence.
module lfsr_step_n #(
  parameter int NUM_OF_STEPS = lfsr_pkg::DEF_NUM_OF_STEPS
) (
  input  logic [lfsr_pkg::POLY_WIDTH-1:0] state_i,
  output logic [lfsr_pkg::POLY_WIDTH-1:0] state_o
);
  import lfsr_pkg::*;

  always_comb begin
    state_o = state_i;
    for (int i = 0; i < NUM_OF_STEPS; i++) begin
      state_o = lfsr_step(state_o);
    end
  end

endmodule

// File: rtl/lfsr_descrambler_rx.sv
// Receive-side descrambler: software-seeded LFSR, sync-word alignment check and a
// single-entry registered valid/ready output stage.
module lfsr_descrambler_rx #(
  parameter int                    POLY_WIDTH   = lfsr_pkg::POLY_WIDTH,
  parameter int                    NUM_OF_STEPS = lfsr_pkg::DEF_NUM_OF_STEPS,
  parameter int                    DATA_WIDTH   = lfsr_pkg::DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD    = DATA_WIDTH'(lfsr_pkg::DEF_SYNC_WORD),
  parameter logic [11:0]           ADDR_SEED_LO = lfsr_pkg::ADDR_SEED_LO,
  parameter logic [11:0]           ADDR_SEED_HI = lfsr_pkg::ADDR_SEED_HI
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write,
  input  logic [11:0]           addr,
  input  logic [31:0]           lfsrdin,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  locked,
  output logic                  seed_err,
  output logic [7:0]            sync_err_cnt,
  output logic [POLY_WIDTH-1:0] lfsr_state
);
  import lfsr_pkg::*;

  if (POLY_WIDTH != 34) begin : g_bad_poly_width
    $error("lfsr_descrambler_rx: tap set only defined for POLY_WIDTH = 34");
  end
  if (NUM_OF_STEPS < 1 || NUM_OF_STEPS > POLY_WIDTH) begin : g_bad_steps
    $error("lfsr_descrambler_rx: NUM_OF_STEPS must be in 1..POLY_WIDTH");
  end
  if (DATA_WIDTH > POLY_WIDTH) begin : g_bad_data_width
    $error("lfsr_descrambler_rx: DATA_WIDTH must not exceed POLY_WIDTH");
  end

  rx_state_e             fsm_q, fsm_d;
  logic [POLY_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic                  outValid_q, outValid_d;
  logic                  locked_q, locked_d;
  logic                  seedErr_q, seedErr_d;
  logic [7:0]            syncErrCnt_q, syncErrCnt_d;

  logic                  seedLoWr, seedHiWr, seedWr, accept;
  logic [POLY_WIDTH-1:0] lfsrAdvanced, seedHiState;
  logic [DATA_WIDTH-1:0] keystream, descrambled;

  assign seedLoWr    = write && (addr == ADDR_SEED_LO);
  assign seedHiWr    = write && (addr == ADDR_SEED_HI);
  assign seedWr      = seedLoWr || seedHiWr;
  assign seedHiState = {lfsrdin[1:0], lfsr_q[31:0]};

  // Keystream is taken from the state before this beat's advance.
  assign keystream   = lfsr_q[POLY_WIDTH-1 -: DATA_WIDTH];
  assign descrambled = in_data ^ keystream;

  assign in_ready = (fsm_q != IDLE) && !seedWr && (!outValid_q || out_ready);
  assign accept   = in_valid && in_ready;

  lfsr_step_n #(
    .NUM_OF_STEPS(NUM_OF_STEPS)
  ) u_step (
    .state_i(lfsr_q),
    .state_o(lfsrAdvanced)
  );

  always_comb begin
    fsm_d        = fsm_q;
    lfsr_d       = lfsr_q;
    outData_d    = outData_q;
    outValid_d   = outValid_q;
    locked_d     = locked_q;
    seedErr_d    = seedErr_q;
    syncErrCnt_d = syncErrCnt_q;

    if (seedLoWr) begin
      lfsr_d[31:0] = lfsrdin;
    end else if (seedHiWr) begin
      lfsr_d   = seedHiState;
      locked_d = 1'b0;
      if (seedHiState != '0) begin
        fsm_d     = ARMED;
        seedErr_d = 1'b0;
      end else begin
        fsm_d     = IDLE;
        seedErr_d = 1'b1;
      end
    end else if (accept) begin
      lfsr_d = lfsrAdvanced;
      if (fsm_q == ARMED) begin
        if (descrambled == SYNC_WORD) begin
          fsm_d    = LOCKED;
          locked_d = 1'b1;
        end else begin
          fsm_d = FAIL;
          if (syncErrCnt_q != 8'hFF) begin
            syncErrCnt_d = syncErrCnt_q + 8'd1;
          end
        end
      end
    end

    // A pending beat survives a re-arm; it only leaves through a handshake.
    if (accept && fsm_q == LOCKED) begin
      outValid_d = 1'b1;
      outData_d  = descrambled;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= IDLE;
      lfsr_q       <= '0;
      outData_q    <= '0;
      outValid_q   <= 1'b0;
      locked_q     <= 1'b0;
      seedErr_q    <= 1'b0;
      syncErrCnt_q <= '0;
    end else begin
      fsm_q        <= fsm_d;
      lfsr_q       <= lfsr_d;
      outData_q    <= outData_d;
      outValid_q   <= outValid_d;
      locked_q     <= locked_d;
      seedErr_q    <= seedErr_d;
      syncErrCnt_q <= syncErrCnt_d;
    end
  end

  assign out_data     = outData_q;
  assign out_valid    = outValid_q;
  assign locked       = locked_q;
  assign seed_err     = seedErr_q;
  assign sync_err_cnt = syncErrCnt_q;
  assign lfsr_state   = lfsr_q;

endmodule

// File: tb/tb_lfsr_descrambler_rx.sv
// Self-checking bench for lfsr_descrambler_rx: directed vector table, hand-written corner
// sequences and a randomized run against a polynomial-arithmetic reference model.
module tb_lfsr_descrambler_rx;

  localparam logic [11:0] A_LO = 12'h0b1;
  localparam logic [11:0] A_HI = 12'h0b2;
  localparam logic [17:0] SYNC = 18'h2A5C3;
  localparam logic [33:0] POLY_MASK = 34'h0_0002_1101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write;
  logic [11:0] addr;
  logic [31:0] lfsrdin;
  logic [17:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        locked;
  logic        seed_err;
  logic [7:0]  sync_err_cnt;
  logic [33:0] lfsr_state;

  int total = 0;
  int bad   = 0;
  bit lastReady;

  // Reference model state: mode 0 idle, 1 armed, 2 locked, 3 sync failed.
  logic [33:0] mState;
  int          mMode;
  bit          mLocked, mSeedErr, mOv;
  int          mCnt;
  logic [17:0] mOd;

  lfsr_descrambler_rx dut (
    .clk(clk), .rst_n(rst_n), .write(write), .addr(addr), .lfsrdin(lfsrdin),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .locked(locked), .seed_err(seed_err), .sync_err_cnt(sync_err_cnt),
    .lfsr_state(lfsr_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Multiplication by x modulo the feedback polynomial, one step per iteration.
  function automatic logic [33:0] polyAdvance(input logic [33:0] s, input int n);
    logic [33:0] r;
    logic [34:0] wide;
    r = s;
    for (int i = 0; i < n; i++) begin
      wide = {1'b0, r} * 35'd2;
      r    = wide[33:0];
      if (wide[34]) r = r ^ POLY_MASK;
    end
    return r;
  endfunction

  function automatic bit modelReady(input bit wr, input logic [11:0] a, input bit ordy);
    bit seedWr;
    seedWr = wr && (a == A_LO || a == A_HI);
    return (mMode != 0) && !seedWr && (!mOv || ordy);
  endfunction

  task automatic modelReset();
    mState = '0; mMode = 0; mLocked = 0; mSeedErr = 0; mOv = 0; mCnt = 0; mOd = '0;
  endtask

  task automatic modelClock(input bit wr, input logic [11:0] a, input logic [31:0] din,
                            input bit iv, input logic [17:0] id, input bit ordy);
    bit          acc;
    int          oldMode;
    logic [17:0] ks;
    logic [33:0] newS;
    acc     = iv && modelReady(wr, a, ordy);
    oldMode = mMode;
    ks      = 18'(mState >> 16);
    if (wr && a == A_LO) begin
      mState[31:0] = din;
    end else if (wr && a == A_HI) begin
      newS    = {din[1:0], mState[31:0]};
      mState  = newS;
      mLocked = 0;
      if (newS != 0) begin mMode = 1; mSeedErr = 0; end
      else begin mMode = 0; mSeedErr = 1; end
    end else if (acc) begin
      if (oldMode == 1) begin
        if ((id ^ ks) == SYNC) begin mMode = 2; mLocked = 1; end
        else begin mMode = 3; if (mCnt < 255) mCnt++; end
      end
      mState = polyAdvance(mState, 18);
    end
    if (acc && oldMode == 2) begin mOv = 1; mOd = id ^ ks; end
    else if (ordy) mOv = 0;
  endtask

  task automatic compareAll();
    checkOutput("out_valid", 64'(out_valid), 64'(mOv));
    if (mOv) checkOutput("out_data", 64'(out_data), 64'(mOd));
    checkOutput("locked", 64'(locked), 64'(mLocked));
    checkOutput("seed_err", 64'(seed_err), 64'(mSeedErr));
    checkOutput("sync_err_cnt", 64'(sync_err_cnt), 64'(mCnt));
    checkOutput("lfsr_state", 64'(lfsr_state), 64'(mState));
  endtask

  // Called just after a rising edge; drives one cycle and checks before and after the edge.
  task automatic applyStimulus(input bit wr, input logic [11:0] a, input logic [31:0] din,
                               input bit iv, input logic [17:0] id, input bit ordy);
    write = wr; addr = a; lfsrdin = din; in_valid = iv; in_data = id; out_ready = ordy;
    #2;
    lastReady = in_ready;
    checkOutput("in_ready", 64'(in_ready), 64'(modelReady(wr, a, ordy)));
    @(posedge clk);
    modelClock(wr, a, din, iv, id, ordy);
    #1;
    compareAll();
  endtask

  task automatic idleInputs();
    write = 0; addr = '0; lfsrdin = '0; in_valid = 0; in_data = '0; out_ready = 0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] a;
    logic [31:0] din;
    bit          iv;
    logic [17:0] id;
    bit          ordy;
    bit          eRdy;
    bit          eOv;
    logic [17:0] eOd;
    bit          eLocked;
    logic [33:0] eState;
  } vec_t;

  vec_t        vecs[5];
  logic [17:0] held;

  initial begin
    vecs[0] = '{1, A_LO, 32'h1, 0, 18'h0,     1, 0, 0, 18'h0, 0, 34'h0_0000_0001};
    vecs[1] = '{1, A_HI, 32'h0, 1, 18'h2A5C3, 1, 0, 0, 18'h0, 0, 34'h0_0000_0001};
    vecs[2] = '{0, 12'h0, 32'h0, 1, 18'h2A5C3, 1, 1, 0, 18'h0, 1, 34'h0_0004_0000};
    vecs[3] = '{0, 12'h0, 32'h0, 1, 18'h00004, 1, 1, 1, 18'h0, 1, 34'h0_0008_4404};
    vecs[4] = '{0, 12'h0, 32'h0, 0, 18'h0,     1, 1, 0, 18'h0, 1, 34'h0_0008_4404};

    // Reset state, checked while reset is still held.
    idleInputs();
    rst_n = 1'b0;
    modelReset();
    #2;
    checkOutput("reset_in_ready", 64'(in_ready), 64'h0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'h0);
    checkOutput("reset_locked", 64'(locked), 64'h0);
    checkOutput("reset_lfsr_state", 64'(lfsr_state), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed lock sequence from the vector table.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].a, vecs[i].din, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      checkOutput($sformatf("vec%0d_in_ready", i), 64'(lastReady), 64'(vecs[i].eRdy));
      checkOutput($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].eOv));
      if (vecs[i].eOv) checkOutput($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].eOd));
      checkOutput($sformatf("vec%0d_locked", i), 64'(locked), 64'(vecs[i].eLocked));
      checkOutput($sformatf("vec%0d_lfsr_state", i), 64'(lfsr_state), 64'(vecs[i].eState));
    end

    // Backpressure: out_ready low for three cycles with input offered.
    applyStimulus(0, 12'h0, 32'h0, 1, 18'($urandom), 1);
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 12'h0, 32'h0, 1, 18'($urandom), 0);
      checkOutput("stall_in_ready", 64'(lastReady), 64'h0);
      checkOutput("stall_out_valid", 64'(out_valid), 64'h1);
      checkOutput("stall_out_data", 64'(out_data), 64'(held));
    end
    for (int i = 0; i < 5; i++) applyStimulus(0, 12'h0, 32'h0, 1, 18'($urandom), 1);

    // Asynchronous reset between clock edges with a beat pending.
    applyStimulus(0, 12'h0, 32'h0, 1, 18'($urandom), 0);
    #3 rst_n = 1'b0;
    modelReset();
    idleInputs();
    #1;
    checkOutput("async_rst_out_valid", 64'(out_valid), 64'h0);
    checkOutput("async_rst_out_data", 64'(out_data), 64'h0);
    checkOutput("async_rst_locked", 64'(locked), 64'h0);
    checkOutput("async_rst_lfsr_state", 64'(lfsr_state), 64'h0);
    checkOutput("async_rst_in_ready", 64'(in_ready), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Sync mismatch, dropped beats, then recovery by re-seeding.
    applyStimulus(1, A_LO, 32'h1, 0, 18'h0, 1);
    applyStimulus(1, A_HI, 32'h0, 0, 18'h0, 1);
    applyStimulus(0, 12'h0, 32'h0, 1, 18'h0, 1);
    checkOutput("fail_sync_err_cnt", 64'(sync_err_cnt), 64'h1);
    checkOutput("fail_locked", 64'(locked), 64'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 12'h0, 32'h0, 1, 18'($urandom), 1);
      checkOutput("fail_drop_out_valid", 64'(out_valid), 64'h0);
    end
    applyStimulus(1, A_LO, 32'h1, 0, 18'h0, 1);
    applyStimulus(1, A_HI, 32'h0, 0, 18'h0, 1);
    applyStimulus(0, 12'h0, 32'h0, 1, SYNC, 1);
    checkOutput("recover_locked", 64'(locked), 64'h1);

    // All-zero seed is rejected; a later non-zero seed clears the error.
    applyStimulus(1, A_LO, 32'h0, 0, 18'h0, 1);
    applyStimulus(1, A_HI, 32'h0, 0, 18'h0, 1);
    checkOutput("zero_seed_err", 64'(seed_err), 64'h1);
    applyStimulus(0, 12'h0, 32'h0, 1, 18'h1, 1);
    checkOutput("zero_seed_in_ready", 64'(lastReady), 64'h0);
    applyStimulus(1, A_LO, 32'h5, 0, 18'h0, 1);
    applyStimulus(1, A_HI, 32'h0, 0, 18'h0, 1);
    checkOutput("reseed_seed_err", 64'(seed_err), 64'h0);

    // Seed write takes priority over an offered beat.
    applyStimulus(1, A_HI, 32'h3, 1, 18'h12345, 1);
    checkOutput("seedwr_in_ready", 64'(lastReady), 64'h0);
    checkOutput("seedwr_lfsr_state", 64'(lfsr_state), 64'h3_0000_0005);

    // Counter saturation after 256 sync failures.
    doReset();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1, A_LO, 32'h1, 0, 18'h0, 1);
      applyStimulus(1, A_HI, 32'h0, 0, 18'h0, 1);
      applyStimulus(0, 12'h0, 32'h0, 1, 18'h0, 1);
    end
    checkOutput("sat_sync_err_cnt", 64'(sync_err_cnt), 64'hFF);

    // Randomized traffic with occasional re-arms, checked against the model every cycle.
    doReset();
    applyStimulus(1, A_LO, $urandom, 0, 18'h0, 1);
    applyStimulus(1, A_HI, 32'($urandom_range(3, 1)), 0, 18'h0, 1);
    for (int i = 0; i < 1500; i++) begin
      int          pick;
      logic [17:0] id;
      pick = int'($urandom_range(99));
      if (mMode == 1 && $urandom_range(3) != 0) id = SYNC ^ 18'(mState >> 16);
      else id = 18'($urandom);
      if (pick == 0)
        applyStimulus(1, A_HI, 32'($urandom_range(3, 1)), $urandom_range(1) == 1, id, $urandom_range(3) != 0);
      else if (pick == 1)
        applyStimulus(1, A_LO, $urandom, $urandom_range(1) == 1, id, $urandom_range(3) != 0);
      else
        applyStimulus(0, 12'h0, 32'h0, $urandom_range(3) != 0, id, $urandom_range(3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
